// File: rtl/param_serial_encoder.sv
// Parallel-to-serial encoder: accepts a WIDTH-bit word on valid/ready and shifts it out one bit per clock.
// Optional parity bit after the data bits when SERIAL_ENCODER_PARITY_EN is defined.
module param_serial_encoder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             inValid,
  output logic             inReady,
  output logic             serialOut,
  output logic             frameStart,
  output logic             lastBit,
  output logic             busy
);

`ifdef SERIAL_ENCODER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_serial_out;
  logic             w_serial_nxt;
  logic             r_frame_start;
  logic             w_frame_start_nxt;
  logic             r_last_bit;
  logic             w_last_bit_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_head_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic [WIDTH-1:0] w_adv_shift;
`ifdef SERIAL_ENCODER_PARITY_EN
  logic             r_parity;
  logic             w_parity_nxt;
`endif

  // The shift register holds only the bits still to be sent, aligned so the
  // next one is always at the head end.
  assign w_first_bit  = MSB_FIRST ? parallelIn[WIDTH-1] : parallelIn[0];
  assign w_load_shift = MSB_FIRST ? {parallelIn[WIDTH-2:0], 1'b0}
                                  : {1'b0, parallelIn[WIDTH-1:1]};
  assign w_head_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_adv_shift  = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shift[WIDTH-1:1]};
  assign w_cnt_inc    = r_cnt + 1'b1;

  // Ready during the final bit lets the next word follow without a gap.
  assign inReady  = ~reset & ((r_state == S_IDLE) | r_last_bit);
  assign w_accept = inValid & inReady;

  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_cnt_nxt         = '0;
    w_serial_nxt      = IDLE_LEVEL;
    w_frame_start_nxt = 1'b0;
    w_last_bit_nxt    = 1'b0;
    w_busy_nxt        = 1'b0;
`ifdef SERIAL_ENCODER_PARITY_EN
    w_parity_nxt      = r_parity;
`endif
    if (w_accept) begin
      w_state_nxt       = S_SHIFT;
      w_shift_nxt       = w_load_shift;
      w_cnt_nxt         = CNT_W'(1);
      w_serial_nxt      = w_first_bit;
      w_frame_start_nxt = 1'b1;
      w_busy_nxt        = 1'b1;
`ifdef SERIAL_ENCODER_PARITY_EN
      w_parity_nxt      = (^parallelIn) ^ ODD_PARITY;
`endif
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_last_bit) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_busy_nxt     = 1'b1;
            w_cnt_nxt      = w_cnt_inc;
            w_last_bit_nxt = (w_cnt_inc == CNT_W'(FRAME_LEN));
            w_serial_nxt   = w_head_bit;
            w_shift_nxt    = w_adv_shift;
`ifdef SERIAL_ENCODER_PARITY_EN
            if (r_cnt == CNT_W'(WIDTH)) begin
              w_serial_nxt = r_parity;
            end
`endif
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_serial_out  <= IDLE_LEVEL;
      r_frame_start <= 1'b0;
      r_last_bit    <= 1'b0;
      r_busy        <= 1'b0;
`ifdef SERIAL_ENCODER_PARITY_EN
      r_parity      <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_cnt         <= w_cnt_nxt;
      r_serial_out  <= w_serial_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_last_bit    <= w_last_bit_nxt;
      r_busy        <= w_busy_nxt;
`ifdef SERIAL_ENCODER_PARITY_EN
      r_parity      <= w_parity_nxt;
`endif
    end
  end

  assign serialOut  = r_serial_out;
  assign frameStart = r_frame_start;
  assign lastBit    = r_last_bit;
  assign busy       = r_busy;

endmodule

// File: tb/tb_param_serial_encoder.sv
// Bench for param_serial_encoder: an LSB-first and an MSB-first instance share stimulus;
// expected bits are queued on each accept and compared every cycle.
module tb_param_serial_encoder;

  localparam int W        = 8;
  localparam bit IDLE_LVL = 1'b0;
  localparam bit ODD_L    = 1'b0;
  localparam bit ODD_M    = 1'b1;

  typedef struct packed {
    logic ser;
    logic fs;
    logic lb;
  } bit_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] parallelIn;
  logic         inValid;
  logic         rdy_l, ser_l, fs_l, lb_l, busy_l;
  logic         rdy_m, ser_m, fs_m, lb_m, busy_m;

  int   vectors = 0;
  int   errors  = 0;
  bit_t q_l[$];
  bit_t q_m[$];
  logic acc;

  always #5 clock = ~clock;

  param_serial_encoder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE_LVL), .ODD_PARITY(ODD_L)) dut_l (
    .clock(clock), .reset(reset), .parallelIn(parallelIn), .inValid(inValid),
    .inReady(rdy_l), .serialOut(ser_l), .frameStart(fs_l), .lastBit(lb_l), .busy(busy_l)
  );

  param_serial_encoder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE_LVL), .ODD_PARITY(ODD_M)) dut_m (
    .clock(clock), .reset(reset), .parallelIn(parallelIn), .inValid(inValid),
    .inReady(rdy_m), .serialOut(ser_m), .frameStart(fs_m), .lastBit(lb_m), .busy(busy_m)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    bit_t b;
    bit   par_en;
`ifdef SERIAL_ENCODER_PARITY_EN
    par_en = 1'b1;
`else
    par_en = 1'b0;
`endif
    for (int k = 0; k < W; k++) begin
      b.fs = (k == 0);
      b.lb = (k == W - 1) && !par_en;
      b.ser = w[k];
      q_l.push_back(b);
      b.ser = w[W-1-k];
      q_m.push_back(b);
    end
    if (par_en) begin
      b.fs  = 1'b0;
      b.lb  = 1'b1;
      b.ser = (^w) ^ ODD_L;
      q_l.push_back(b);
      b.ser = (^w) ^ ODD_M;
      q_m.push_back(b);
    end
  endtask

  task automatic chk_outputs();
    bit_t el, em;
    logic be;
    if (q_l.size() != 0) begin
      el = q_l[0];
      em = q_m[0];
      be = 1'b1;
    end else begin
      el = '{ser: IDLE_LVL, fs: 1'b0, lb: 1'b0};
      em = el;
      be = 1'b0;
    end
    chk("serial_lsb", ser_l, el.ser);
    chk("fstart_lsb", fs_l, el.fs);
    chk("lastbit_lsb", lb_l, el.lb);
    chk("busy_lsb", busy_l, be);
    chk("serial_msb", ser_m, em.ser);
    chk("fstart_msb", fs_m, em.fs);
    chk("lastbit_msb", lb_m, em.lb);
    chk("busy_msb", busy_m, be);
  endtask

  // One clock: check ready before the edge, update the model at the edge,
  // check registered outputs on the falling edge.
  task automatic cycle(output logic accepted);
    logic exp_rdy;
    #1;
    exp_rdy = !reset && (q_l.size() == 0 || q_l[0].lb);
    chk("inReady_lsb", rdy_l, exp_rdy);
    chk("inReady_msb", rdy_m, exp_rdy);
    accepted = inValid && exp_rdy;
    @(posedge clock);
    if (reset) begin
      q_l.delete();
      q_m.delete();
    end else begin
      if (q_l.size() != 0) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (accepted) push_frame(parallelIn);
    end
    @(negedge clock);
    chk_outputs();
  endtask

  task automatic send(input logic [W-1:0] word);
    logic a;
    a = 1'b0;
    parallelIn = word;
    inValid    = 1'b1;
    for (int n = 0; n < 40 && !a; n++) cycle(a);
    if (!a) chk("send_timeout", a, 1'b1);
  endtask

  task automatic idle(input int n);
    logic a;
    inValid = 1'b0;
    for (int i = 0; i < n; i++) begin
      parallelIn = W'($urandom);
      cycle(a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    inValid    = 1'b0;
    parallelIn = '0;
    cycle(acc);
    cycle(acc);
    reset = 1'b0;
    idle(10);

    // Single frame: LSB-first gives 1,0,0,0,0,0,1,1 and MSB-first 1,1,0,0,0,0,0,1.
    send(8'hC1);
    idle(12);

    // Back-to-back frames with inValid held across the boundary.
    send(8'hC1);
    send(8'h0F);
    idle(12);

    // Reset after three bits of a frame.
    send(8'hFF);
    idle(2);
    reset = 1'b1;
    cycle(acc);
    cycle(acc);
    reset = 1'b0;
    idle(3);

    // Reset and inValid together: nothing is accepted.
    reset      = 1'b1;
    inValid    = 1'b1;
    parallelIn = 8'hA5;
    cycle(acc);
    cycle(acc);
    reset = 1'b0;
    idle(2);

    // Random back-to-back stream.
    for (int i = 0; i < 4; i++) send(W'($urandom));
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/param_serial_encoder.md
Name: param_serial_encoder

Overview:
Parametrised parallel-to-serial encoder, the successor to the fixed 8-bit PISO encoder. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, either MSB-first or LSB-first. Words can stream back-to-back with no idle gap. Framing strobes are provided so the downstream serial decoder and line logic can align.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..64
MSB_FIRST, 0, 1 = shift parallelIn[WIDTH-1] first; 0 = shift parallelIn[0] first
IDLE_LEVEL, 0, value driven on serialOut when no frame is active
ODD_PARITY, 0, parity sense; used only when the optional feature is compiled in (0 = even, 1 = odd)

Ports:
clock  input  1  single system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
parallelIn  input  WIDTH  word to encode; sampled only on an accept edge
inValid  input  1  upstream has a word on parallelIn
inReady  output  1  encoder can accept a word this cycle
serialOut  output  1  registered serial data
frameStart  output  1  high during the first bit cycle of each frame
lastBit  output  1  high during the final bit cycle of each frame
busy  output  1  high while any frame bit is on serialOut

Behaviour:
- Reset, sampled on a clock edge while reset=1:
  - next cycle: serialOut=IDLE_LEVEL, frameStart=0, lastBit=0, busy=0, bit counter=0, state=IDLE.
  - inReady=0 while reset=1; inReady=1 on the first cycle after reset deasserts.
- States:
  - IDLE: serialOut=IDLE_LEVEL, busy=0, inReady=1.
  - SHIFT: busy=1; a bit counter of width clog2(WIDTH+1) counts bits already sent.
- Accept: a word is accepted on an edge where inValid and inReady are both 1. parallelIn is captured into an internal shift register at that edge.
- Latency: if the accept edge is edge N, the first bit is on serialOut in the cycle after edge N, with frameStart=1. Bit k (k=0..WIDTH-1) appears k cycles later.
- Bit order:
  - MSB_FIRST=1: parallelIn[WIDTH-1] down to [0].
  - MSB_FIRST=0: parallelIn[0] up to [WIDTH-1].
- lastBit=1 only in the cycle carrying the final frame bit.
- inReady in SHIFT equals lastBit, so a word can be accepted during the final bit cycle.
- Back-to-back: if a word is accepted while lastBit=1, its first bit follows immediately.
  - frameStart=1 in that cycle, busy stays 1, no IDLE_LEVEL gap.
  - If no word is accepted in the lastBit cycle, return to IDLE and drive IDLE_LEVEL.
- inValid while inReady=0 is ignored; upstream must hold the word stable until accepted. parallelIn changes between accepts have no effect.
- Reset mid-frame: the frame is aborted and the remaining bits discarded. Outputs take reset values next cycle, with no partial lastBit pulse.
- reset and inValid high together: reset wins; no word is accepted.
- WIDTH=2 is legal; frameStart and lastBit then occur on consecutive cycles.

Optional Feature:
Macro SERIAL_ENCODER_PARITY_EN.
- Defined:
  - One parity bit follows the WIDTH data bits, so a frame is WIDTH+1 cycles.
  - Parity bit = XOR of the captured data bits, XORed with ODD_PARITY.
  - lastBit and the early inReady move to the parity cycle.
  - The counter width is clog2(WIDTH+2).
- Not defined: frames are exactly WIDTH cycles, no parity logic is synthesised, and ODD_PARITY is ignored.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles, then inValid=0 for 10 cycles -> serialOut=IDLE_LEVEL, busy=0, inReady=1 throughout idle.
2. WIDTH=8, MSB_FIRST=0, parallelIn=8'hC1 accepted -> serialOut 1,0,0,0,0,0,1,1 on the 8 following cycles; frameStart on bit 0; lastBit on bit 7; then IDLE_LEVEL.
3. WIDTH=8, MSB_FIRST=1, parallelIn=8'hC1 -> serialOut 1,1,0,0,0,0,0,1.
4. Back-to-back: 8'hC1 then 8'h0F with inValid held, MSB_FIRST=0 -> 16 contiguous bits 1,0,0,0,0,0,1,1,1,1,1,1,0,0,0,0; frameStart at bits 0 and 8; busy never drops.
5. Reset mid-frame: accept 8'hFF, assert reset after 3 bits -> next cycle serialOut=IDLE_LEVEL, busy=0, lastBit never pulsed; inReady=1 after release.
6. SERIAL_ENCODER_PARITY_EN, ODD_PARITY=0, 8'hC1 -> 9th bit = 1 (three ones); lastBit on 9th bit. Same word with ODD_PARITY=1 -> 9th bit = 0.
